// File: rtl/axi_pkg.sv
// Shared AXI-Lite write-path types and widths.
// Reused by axi_slave and future read-channel blocks.
package axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic BRESP_OKAY = 1'b0;
  localparam logic BRESP_ERR  = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    WAIT_B    = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/axi_write_master_timeout.sv
// Transaction watchdog: counts enabled cycles since clear.
// expired flags the last permitted cycle before abort.
module axi_timeout_counter #(
  parameter int CNT_W = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == limit - CNT_W'(1));

endmodule

// File: rtl/axi_write_master.sv
// Single-outstanding AXI-Lite write master: AW/W issue,
// B collection and a timeout abort path.
module axi_write_master
  import axi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [STRB_W-1:0] cmd_strb,
  output logic              done,
  output logic              done_err,
  output logic              done_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  output logic              BREADY,
  input  logic              BRESP,
  input  logic              BVALID
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              to_q, to_d;
  logic              busy_q, busy_d;

  logic accept;
  logic cnt_en;
  logic expired;

  assign accept = (state_q == IDLE) && cmd_valid;
  assign cnt_en = (state_q == ADDR_DATA) ||
                  (state_q == WAIT_B);

  axi_timeout_counter #(
    .CNT_W (CNT_W)
  ) u_timeout (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .clear   (accept),
    .enable  (cnt_en),
    .limit   (CNT_W'(TIMEOUT_CYCLES)),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    to_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          awaddr_d  = cmd_addr;
          wdata_d   = cmd_data;
          wstrb_d   = cmd_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ADDR_DATA;
        end
      end
      ADDR_DATA: begin
        awvalid_d = awvalid_q && !AWREADY;
        wvalid_d  = wvalid_q && !WREADY;
        if (expired) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          done_d    = 1'b1;
          err_d     = BRESP_ERR;
          to_d      = 1'b1;
          state_d   = DONE;
        end else if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WAIT_B;
        end
      end
      WAIT_B: begin
        // A response on the expiry cycle still counts.
        if (BVALID && bready_q) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = (BRESP == BRESP_ERR);
          state_d  = DONE;
        end else if (expired) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = BRESP_ERR;
          to_d     = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      to_q      <= to_d;
      busy_q    <= busy_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign done         = done_q;
  assign done_err     = err_q;
  assign done_timeout = to_q;
  assign busy         = busy_q;
  assign AWADDR       = awaddr_q;
  assign AWVALID      = awvalid_q;
  assign WDATA        = wdata_q;
  assign WSTRB        = wstrb_q;
  assign WVALID       = wvalid_q;
  assign BREADY       = bready_q;

endmodule

// File: tb/tb_axi_write_master.sv
// Bench for axi_write_master: directed table, reset
// abort and randomized slave timing vs window model.
module tb_axi_write_master;

  localparam int TO = 8;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_strb = '0;
  logic        done, done_err, done_timeout, busy;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic        BREADY;
  logic        BRESP = 1'b0;
  logic        BVALID = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_write_master #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_strb     (cmd_strb),
    .done         (done),
    .done_err     (done_err),
    .done_timeout (done_timeout),
    .busy         (busy),
    .AWADDR       (AWADDR),
    .AWVALID      (AWVALID),
    .AWREADY      (AWREADY),
    .WDATA        (WDATA),
    .WSTRB        (WSTRB),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .BREADY       (BREADY),
    .BRESP        (BRESP),
    .BVALID       (BVALID)
  );

  // da/dw/db: cycles the slave withholds each READY/BVALID
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          da;
    int          dw;
    int          db;
    logic        bresp;
    int          exp_dc;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   m;
    r = v;
    m = mx(v.da, v.dw) + 1;
    if (m + v.db <= TO - 1) begin
      r.exp_dc  = m + v.db + 1;
      r.exp_err = v.bresp;
      r.exp_to  = 1'b0;
    end else begin
      r.exp_dc  = TO;
      r.exp_err = 1'b1;
      r.exp_to  = 1'b1;
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at a
  // negedge one cycle after done.
  task automatic run_txn(input vec_t v, input string tag);
    int m, aws, ws, bs, idx;
    logic aw_hs, w_hs, bw, pay_ok;
    logic [8:0] got, exp;
    logic [31:0] cap_a, cap_d, mask;
    logic [3:0] cap_s;
    m = mx(v.da, v.dw) + 1;
    aws = 0; ws = 0; bs = 0;
    aw_hs = 0; w_hs = 0;
    cap_a = '0; cap_d = '0; cap_s = '0;
    chk($sformatf("%s ready", tag), cmd_ready, 1);
    cmd_addr  = v.addr;
    cmd_data  = v.data;
    cmd_strb  = v.strb;
    cmd_valid = 1'b1;
    @(posedge ACLK);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_data  = $urandom;
    cmd_strb  = 4'($urandom);
    for (int k = 0; k <= v.exp_dc; k++) begin
      @(negedge ACLK);
      pay_ok = (!AWVALID || AWADDR == v.addr) &&
               (!WVALID || (WDATA == v.data &&
                            WSTRB == v.strb));
      got = {AWVALID, WVALID, BREADY, done, done_err,
             done_timeout, busy, cmd_ready, pay_ok};
      bw  = (m <= TO - 1) && (k >= m) &&
            (k <= mn(m + v.db, TO - 1));
      exp = {k <= mn(v.da, TO - 1),
             k <= mn(v.dw, TO - 1), bw,
             k == v.exp_dc,
             (k == v.exp_dc) && v.exp_err,
             (k == v.exp_dc) && v.exp_to,
             1'b1, 1'b0, 1'b1};
      chk($sformatf("%s cyc%0d", tag, k), got, exp);
      if (AWVALID) begin
        AWREADY = (aws == v.da);
        if (AWREADY) begin aw_hs = 1; cap_a = AWADDR; end
        aws++;
      end else AWREADY = 1'($urandom);
      if (WVALID) begin
        WREADY = (ws == v.dw);
        if (WREADY) begin
          w_hs = 1; cap_d = WDATA; cap_s = WSTRB;
        end
        ws++;
      end else WREADY = 1'($urandom);
      if (BREADY) begin
        BVALID = (bs == v.db);
        bs++;
      end else BVALID = 1'($urandom);
      BRESP = (BVALID && BREADY) ? v.bresp
                                 : 1'($urandom);
    end
    @(negedge ACLK);
    AWREADY = 0; WREADY = 0; BVALID = 0;
    chk($sformatf("%s idle", tag),
        {busy, done, done_err, done_timeout, cmd_ready},
        5'b00001);
    if (aw_hs && w_hs)
      for (int i = 0; i < 4; i++)
        if (cap_s[i])
          slv_mem[cap_a[5:2]][8*i +: 8] = cap_d[8*i +: 8];
    idx = int'(v.addr[5:2]);
    if (v.da <= TO - 1 && v.dw <= TO - 1) begin
      mask = '0;
      for (int i = 0; i < 4; i++)
        if (v.strb[i]) mask = mask | (32'hFF << (8 * i));
      ref_mem[idx] = (ref_mem[idx] & ~mask) |
                     (v.data & mask);
    end
    chk($sformatf("%s mem", tag), slv_mem[idx],
        ref_mem[idx]);
  endtask

  vec_t tbl [9];
  vec_t rv;

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    //        addr    data          strb  da dw db bresp dc err to
    tbl[0] = '{32'h04, 32'hA1B2C3D4, 4'hF, 0, 0, 0, 0, 2, 0, 0};
    tbl[1] = '{32'h0C, 32'hA1B2C3D4, 4'h3, 0, 3, 0, 0, 5, 0, 0};
    tbl[2] = '{32'h10, 32'h11223344, 4'hC, 3, 0, 0, 0, 5, 0, 0};
    tbl[3] = '{32'h20, 32'h55667788, 4'hF, 0, 0, 20, 0, 8, 1, 1};
    tbl[4] = '{32'h14, 32'hDEADBEEF, 4'h5, 0, 0, 0, 1, 2, 1, 0};
    tbl[5] = '{32'h08, 32'hCAFEF00D, 4'hF, 1, 1, 1, 0, 4, 0, 0};
    tbl[6] = '{32'h18, 32'h0BADF00D, 4'h0, 2, 2, 4, 0, 8, 0, 0};
    tbl[7] = '{32'h1C, 32'h12345678, 4'hF, 2, 2, 5, 0, 8, 1, 1};
    tbl[8] = '{32'h24, 32'h87654321, 4'hF, 9, 0, 0, 0, 8, 1, 1};

    #1;
    chk("reset ctl",
        {AWVALID, WVALID, BREADY, done, done_err,
         done_timeout, busy}, 7'b0);
    chk("reset pay", {AWADDR, WDATA[27:0], WSTRB}, 64'h0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    for (int i = 0; i < 9; i++)
      run_txn(tbl[i], $sformatf("t%0d", i));
    chk("strb3 word", slv_mem[3], 32'h0000C3D4);

    @(negedge ACLK);
    cmd_addr = 32'h28; cmd_data = 32'hFFFF0000;
    cmd_strb = 4'hF;  cmd_valid = 1'b1;
    @(posedge ACLK);
    #1;
    cmd_valid = 1'b0;
    @(negedge ACLK);
    chk("mid valids", {AWVALID, WVALID, busy}, 3'b111);
    #2;
    ARESET = 1'b0;
    #1;
    chk("async drop",
        {AWVALID, WVALID, BREADY, busy, done}, 5'b0);
    repeat (2) begin
      @(negedge ACLK);
      chk("no done in rst", {done, done_err}, 2'b0);
    end
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("rst mem", slv_mem[10], 32'h0);
    rv = '{32'h2C, 32'h01020304, 4'hF, 0, 0, 0, 0, 2, 0, 0};
    run_txn(rv, "post_rst");

    for (int n = 0; n < 40; n++) begin
      rv.addr  = {26'd0, 4'($urandom), 2'b00};
      rv.data  = $urandom;
      rv.strb  = 4'($urandom);
      rv.da    = ($urandom % 8 == 0) ? 9
                                     : int'($urandom % 5);
      rv.dw    = ($urandom % 8 == 0) ? 9
                                     : int'($urandom % 5);
      rv.db    = int'($urandom % 8);
      rv.bresp = 1'($urandom);
      rv = model(rv);
      if ($urandom % 3 == 0)
        repeat ($urandom % 3) @(negedge ACLK);
      run_txn(rv, $sformatf("r%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_write_master.md
Name: axi_write_master

Overview:
AXI-Lite-style single-beat write master that sits directly upstream of axi_slave. It accepts one write command (address, data, byte strobes) from local control logic and drives the AW and W channels. It then collects the B response and reports completion with an OKAY/error/timeout status. Only one transaction is outstanding at a time.

Parameters:
TIMEOUT_CYCLES, 256, max cycles from command accept to B handshake before abort; range 2..65535
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when the master is IDLE and can accept a command
cmd_addr  in  32  write byte address
cmd_data  in  32  write data
cmd_strb  in  4  byte strobes; bit i enables cmd_data[8i+7:8i]
done  out  1  one-cycle completion pulse
done_err  out  1  valid with done; captured BRESP (1 = error)
done_timeout  out  1  valid with done; transaction aborted by timeout
busy  out  1  high in any state other than IDLE
AWADDR  out  32  write address
AWVALID  out  1  address valid
AWREADY  in  1  address ready
WDATA  out  32  write data
WSTRB  out  4  write strobes
WVALID  out  1  data valid
WREADY  in  1  data ready
BREADY  out  1  response ready
BRESP  in  1  response; 0 = OKAY, 1 = error
BVALID  in  1  response valid

Behaviour:
- Reset (ARESET low, asynchronous): state IDLE. AWVALID, WVALID, BREADY, done, done_err, done_timeout, busy all 0. AWADDR, WDATA, WSTRB 0. cmd_ready is 1 once ARESET deasserts.
- All outputs are registered except cmd_ready, which is decoded from state == IDLE.
- States: IDLE, ADDR_DATA, WAIT_B, DONE.
- IDLE: on cmd_valid && cmd_ready, capture addr/data/strb into the AW/W output registers and go to ADDR_DATA. AWVALID and WVALID are both 1 in the next cycle (latency 1). Clear the timeout counter.
- ADDR_DATA: AW and W run independently.
  - AWVALID falls the cycle after the AWVALID && AWREADY edge.
  - WVALID falls the cycle after the WVALID && WREADY edge.
  - Both handshakes may complete in the same cycle or in either order.
  - When both are complete, go to WAIT_B with BREADY = 1.
- Valid rules: AWVALID and WVALID never depend combinationally on the READY inputs. Once asserted, each holds with stable payload until its handshake completes. The master tolerates a slave that asserts WREADY only after AWREADY.
- WAIT_B: on BVALID && BREADY, capture BRESP, drop BREADY, go to DONE. BVALID arriving in ADDR_DATA is ignored because BREADY is 0 there.
- DONE: done = 1 for exactly one cycle with done_err = captured BRESP and done_timeout = 0, then return to IDLE. done_err and done_timeout are 0 whenever done is 0.
- Back-to-back commands: a new command can be accepted in the cycle after DONE. Minimum throughput is one transaction per 4 cycles with zero-wait-state ready signals.
- Timeout:
  - The counter increments every cycle in ADDR_DATA and WAIT_B.
  - When the count reaches TIMEOUT_CYCLES-1 without a B handshake, force AWVALID, WVALID and BREADY to 0 and go to DONE with done_timeout = 1 and done_err = 1.
  - If a B handshake and expiry occur in the same cycle, the handshake wins: done_timeout = 0.
- cmd_strb == 0: accepted and issued normally; no special case.
- cmd_valid while busy: ignored (cmd_ready = 0); the command is not queued.
- Reset mid-transaction: all valids drop immediately and no done is produced. The slave side is reset by the same ARESET.

Decomposition:
- Shared package axi_pkg holds:
  - state encoding constants (IDLE, ADDR_DATA, WAIT_B, DONE);
  - BRESP_OKAY = 0 and BRESP_ERR = 1;
  - address, data and strobe widths (32/32/4) for reuse by axi_slave and future read-channel blocks.
- One sub-module is natural: axi_timeout_counter, with inputs clear, enable and the limit, and an expired output.

Test Plan:
- Zero-wait slave (AWREADY/WREADY/BVALID asserted promptly), cmd addr 0x4, data 0xA1B2C3D4, strb 0xF -> AWVALID/WVALID high the cycle after accept; done one cycle after B handshake with done_err = 0 and done_timeout = 0.
- Slave asserts WREADY 3 cycles after AWREADY, strb 0x3 -> WVALID held with WDATA stable throughout; AWVALID drops alone first; completes OKAY; the slave stores 0xD4 and 0xC3 only.
- WREADY handshake before AWREADY (W first) -> the master still reaches WAIT_B only after both handshakes; BREADY asserts exactly once.
- BVALID withheld, TIMEOUT_CYCLES = 8 -> all valids low and done with done_timeout = 1 and done_err = 1 at cycle 8 after accept; cmd_ready returns the next cycle.
- BRESP = 1 returned -> done_err = 1, done_timeout = 0; an immediate second command (addr 0x8) is accepted the cycle after done.
- ARESET pulsed low while in ADDR_DATA -> AWVALID/WVALID drop asynchronously; no done; after release, cmd_ready = 1 and the next command completes normally.
